// File: rtl/synchronous_fifo_ext.sv
// synchronous_fifo_ext
//   Single-clock FIFO with programmable almost-full/almost-empty thresholds,
//   occupancy count, one-cycle overflow/underflow pulses and an optional
//   first-word-fall-through read port. DEPTH need not be a power of two.
//
// Ports
//   clk, rst       : clock, asynchronous active-high reset
//   w_en, data_in  : write request and data (accepted when not full)
//   r_en           : read request (accepted when not empty)
//   data_out       : read data (registered, or live head when FWFT=1)
//   full, empty    : count == DEPTH / count == 0
//   almost_full    : count >= AF_LEVEL
//   almost_empty   : count <= AE_LEVEL
//   count          : occupancy 0..DEPTH
//   overflow       : pulse, a write was rejected on the previous edge
//   underflow      : pulse, a read was rejected on the previous edge
module synchronous_fifo_ext #(
    parameter int DEPTH    = 16,
    parameter int WIDTH    = 8,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2,
    parameter int FWFT     = 0,
    localparam int CW      = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             w_en,
    input  logic             r_en,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out,
    output logic             full,
    output logic             empty,
    output logic             almost_full,
    output logic             almost_empty,
    output logic [CW-1:0]    count,
    output logic             overflow,
    output logic             underflow
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL_C   = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C     = CW'(AF_LEVEL);
    localparam logic [CW-1:0] AE_C     = CW'(AE_LEVEL);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr, rd_ptr;
    logic [CW-1:0]    count_q;
    logic [WIDTH-1:0] dout_q;
    logic             overflow_q, underflow_q;
    logic             wr_acc, rd_acc;

    // Explicit wrap so non-power-of-two depths index correctly.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    // Flags are pure decodes of the count register.
    assign full         = (count_q == FULL_C);
    assign empty        = (count_q == '0);
    assign almost_full  = (count_q >= AF_C);
    assign almost_empty = (count_q <= AE_C);
    assign count        = count_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

    // When full, a simultaneous read frees a slot only after this edge, so
    // the write is rejected; when empty, the read is rejected symmetrically.
    assign wr_acc = w_en && !full;
    assign rd_acc = r_en && !empty;

    // Storage is intentionally not reset.
    always_ff @(posedge clk) begin
        if (wr_acc)
            mem[wr_ptr] <= data_in;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count_q     <= '0;
            dout_q      <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (wr_acc)
                wr_ptr <= ptr_inc(wr_ptr);
            if (rd_acc) begin
                rd_ptr <= ptr_inc(rd_ptr);
                dout_q <= mem[rd_ptr];
            end
            case ({wr_acc, rd_acc})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            overflow_q  <= w_en && full;
            underflow_q <= r_en && empty;
        end
    end

    // In FWFT mode dout_q holds the last popped word, which is exactly the
    // last head value once the FIFO drains; it also gives data_out = 0 out
    // of reset in both modes.
    if (FWFT != 0) begin : g_fwft
        assign data_out = empty ? dout_q : mem[rd_ptr];
    end else begin : g_reg
        assign data_out = dout_q;
    end

endmodule

// File: tb/tb_synchronous_fifo_ext.sv
module tb_synchronous_fifo_ext;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // DEPTH=16 registered-read instance
    logic       w_a = 0, r_a = 0;
    logic [7:0] din_a = 0, dout_a;
    logic       full_a, empty_a, af_a, ae_a, ovf_a, udf_a;
    logic [4:0] count_a;

    // DEPTH=16 FWFT instance
    logic       w_f = 0, r_f = 0;
    logic [7:0] din_f = 0, dout_f;
    logic       full_f, empty_f, af_f, ae_f, ovf_f, udf_f;
    logic [4:0] count_f;

    // DEPTH=5 instance
    logic       w_5 = 0, r_5 = 0;
    logic [7:0] din_5 = 0, dout_5;
    logic       full_5, empty_5, af_5, ae_5, ovf_5, udf_5;
    logic [2:0] count_5;

    synchronous_fifo_ext #(.DEPTH(16), .WIDTH(8), .AF_LEVEL(14), .AE_LEVEL(2), .FWFT(0)) u_dut (
        .clk(clk), .rst(rst), .w_en(w_a), .r_en(r_a), .data_in(din_a), .data_out(dout_a),
        .full(full_a), .empty(empty_a), .almost_full(af_a), .almost_empty(ae_a),
        .count(count_a), .overflow(ovf_a), .underflow(udf_a));

    synchronous_fifo_ext #(.DEPTH(16), .WIDTH(8), .AF_LEVEL(14), .AE_LEVEL(2), .FWFT(1)) u_fw (
        .clk(clk), .rst(rst), .w_en(w_f), .r_en(r_f), .data_in(din_f), .data_out(dout_f),
        .full(full_f), .empty(empty_f), .almost_full(af_f), .almost_empty(ae_f),
        .count(count_f), .overflow(ovf_f), .underflow(udf_f));

    synchronous_fifo_ext #(.DEPTH(5), .WIDTH(8), .AF_LEVEL(4), .AE_LEVEL(1), .FWFT(0)) u_d5 (
        .clk(clk), .rst(rst), .w_en(w_5), .r_en(r_5), .data_in(din_5), .data_out(dout_5),
        .full(full_5), .empty(empty_5), .almost_full(af_5), .almost_empty(ae_5),
        .count(count_5), .overflow(ovf_5), .underflow(udf_5));

    typedef struct {
        logic       w, r;
        logic [7:0] d;
        int         cnt;
        logic       f, e, af, ae, ovf, udf;
    } vec_t;

    vec_t vecs[$];

    // Scoreboard / reference state for the DEPTH=16 registered instance
    logic [7:0] sb[$];
    int         mcnt  = 0;
    logic [7:0] mdout = 8'h00;
    logic       movf  = 1'b0, mudf = 1'b0;

    // Reference state for the DEPTH=5 instance
    logic [7:0] sb5[$];
    int         m5cnt  = 0;
    logic [7:0] m5dout = 8'h00;
    logic       m5ovf  = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic w, input logic r, input logic [7:0] d,
                                input int cnt, input logic ovf, input logic udf);
        vec_t v;
        v.w = w; v.r = r; v.d = d; v.cnt = cnt;
        v.f = (cnt == 16); v.e = (cnt == 0);
        v.af = (cnt >= 14); v.ae = (cnt <= 2);
        v.ovf = ovf; v.udf = udf;
        return v;
    endfunction

    task automatic drive_a(input logic w, input logic r, input logic [7:0] d);
        logic wacc, racc;
        w_a = w; r_a = r; din_a = d;
        @(posedge clk);
        wacc = w && (mcnt < 16);
        racc = r && (mcnt > 0);
        movf = w && (mcnt == 16);
        mudf = r && (mcnt == 0);
        if (racc) mdout = sb.pop_front();
        if (wacc) sb.push_back(d);
        mcnt = mcnt + int'(wacc) - int'(racc);
        #1;
        w_a = 1'b0; r_a = 1'b0;
        chk("a_dout", dout_a, mdout);
        chk("a_count", count_a, mcnt);
        chk("a_full", full_a, mcnt == 16);
        chk("a_empty", empty_a, mcnt == 0);
        chk("a_ovf", ovf_a, movf);
        chk("a_udf", udf_a, mudf);
    endtask

    task automatic drive_5(input logic w, input logic r, input logic [7:0] d);
        logic wacc, racc;
        w_5 = w; r_5 = r; din_5 = d;
        @(posedge clk);
        wacc  = w && (m5cnt < 5);
        racc  = r && (m5cnt > 0);
        m5ovf = w && (m5cnt == 5);
        if (racc) m5dout = sb5.pop_front();
        if (wacc) sb5.push_back(d);
        m5cnt = m5cnt + int'(wacc) - int'(racc);
        #1;
        w_5 = 1'b0; r_5 = 1'b0;
        chk("d5_dout", dout_5, m5dout);
        chk("d5_count", count_5, m5cnt);
        chk("d5_full", full_5, m5cnt == 5);
        chk("d5_empty", empty_5, m5cnt == 0);
        chk("d5_ovf", ovf_5, m5ovf);
    endtask

    initial begin
        // Table: fill, overflow, drain, underflow, both-at-empty, refill, both-at-full, drain
        for (int i = 0; i < 16; i++) vecs.push_back(mk(1, 0, 8'(i), i + 1, 0, 0));
        vecs.push_back(mk(1, 0, 8'hFF, 16, 1, 0));
        for (int i = 0; i < 16; i++) vecs.push_back(mk(0, 1, 8'h00, 15 - i, 0, 0));
        vecs.push_back(mk(0, 1, 8'h00, 0, 0, 1));
        vecs.push_back(mk(1, 1, 8'h77, 1, 0, 1));
        for (int i = 0; i < 15; i++) vecs.push_back(mk(1, 0, 8'(8'h80 + i), i + 2, 0, 0));
        vecs.push_back(mk(1, 1, 8'hEE, 15, 1, 0));
        for (int i = 0; i < 15; i++) vecs.push_back(mk(0, 1, 8'h00, 14 - i, 0, 0));

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset mid-traffic at count=5
        for (int i = 0; i < 5; i++) drive_a(1, 0, 8'(8'h50 + i));
        rst = 1'b1;
        #2;
        chk("rst_count", count_a, 0);
        chk("rst_empty", empty_a, 1);
        chk("rst_full", full_a, 0);
        chk("rst_ae", ae_a, 1);
        chk("rst_af", af_a, 0);
        chk("rst_ovf", ovf_a, 0);
        chk("rst_udf", udf_a, 0);
        chk("rst_dout", dout_a, 0);
        chk("rst_fw_dout", dout_f, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        sb.delete(); mcnt = 0; mdout = 8'h00; movf = 1'b0; mudf = 1'b0;
        drive_a(1, 0, 8'hA5);
        chk("post_rst_count", count_a, 1);
        chk("post_rst_empty", empty_a, 0);
        drive_a(0, 1, 8'h00);
        chk("post_rst_head", dout_a, 8'hA5);

        // Table-driven flag/boundary walk
        foreach (vecs[i]) begin
            drive_a(vecs[i].w, vecs[i].r, vecs[i].d);
            chk("tbl_count", count_a, vecs[i].cnt);
            chk("tbl_full", full_a, vecs[i].f);
            chk("tbl_empty", empty_a, vecs[i].e);
            chk("tbl_af", af_a, vecs[i].af);
            chk("tbl_ae", ae_a, vecs[i].ae);
            chk("tbl_ovf", ovf_a, vecs[i].ovf);
            chk("tbl_udf", udf_a, vecs[i].udf);
        end

        // 20 writes / 20 reads interleaved across the pointer wrap
        for (int i = 0; i < 20; i++) drive_a(1, i >= 3, 8'(8'h40 + i));
        for (int i = 0; i < 3; i++) drive_a(0, 1, 8'h00);

        // Simultaneous R/W at count=5
        for (int i = 0; i < 5; i++) drive_a(1, 0, 8'(8'hC0 + i));
        for (int i = 0; i < 10; i++) begin
            drive_a(1, 1, 8'(8'hD0 + i));
            chk("rw_count5", count_a, 5);
        end
        for (int i = 0; i < 5; i++) drive_a(0, 1, 8'h00);

        // FWFT: head visible without a read, next word follows an accepted read
        w_f = 1'b1; din_f = 8'h3C;
        @(posedge clk); #1 w_f = 1'b0;
        chk("fw_head", dout_f, 8'h3C);
        chk("fw_empty", empty_f, 0);
        w_f = 1'b1; din_f = 8'h5A;
        @(posedge clk); #1 w_f = 1'b0;
        chk("fw_hold", dout_f, 8'h3C);
        chk("fw_count2", count_f, 2);
        r_f = 1'b1;
        @(posedge clk); #1 r_f = 1'b0;
        chk("fw_next", dout_f, 8'h5A);
        chk("fw_count1", count_f, 1);
        r_f = 1'b1;
        @(posedge clk); #1 r_f = 1'b0;
        chk("fw_drained", empty_f, 1);
        chk("fw_last_head", dout_f, 8'h5A);

        // DEPTH=5: fill, reject, interleave through the wrap, drain
        for (int i = 0; i < 5; i++) drive_5(1, 0, 8'(8'h10 + i));
        chk("d5_full_at5", full_5, 1);
        drive_5(1, 0, 8'hFF);
        for (int i = 0; i < 7; i++) begin
            drive_5(0, 1, 8'h00);
            drive_5(1, 0, 8'(8'h20 + i));
        end
        for (int i = 0; i < 5; i++) drive_5(0, 1, 8'h00);
        chk("d5_sb_empty", sb5.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/synchronous_fifo_ext.md
# synchronous_fifo_ext

Parametrised single-clock FIFO that supersedes the basic synchronous FIFO in the FIFO verification environment. It adds programmable almost-full/almost-empty thresholds, an occupancy count, overflow/underflow error pulses and a selectable first-word-fall-through (FWFT) read mode. It is instantiated in the top-level bench between the FIFO interface and the layered test, and is the DUT for the next round of directed and random tests.

## Interface
- DEPTH, 16: number of entries; any integer ≥ 2 (not restricted to powers of two).
- WIDTH, 8: data word width in bits.
- AF_LEVEL, DEPTH-2: almost_full asserts when count ≥ AF_LEVEL; legal range 1..DEPTH.
- AE_LEVEL, 2: almost_empty asserts when count ≤ AE_LEVEL; legal range 0..DEPTH-1.
- FWFT, 0: 0 = standard registered read; 1 = first-word-fall-through.
- CW (derived, not overridable): $clog2(DEPTH+1).

Ports:
- clk  in  1  sole clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- w_en  in  1  write request.
- r_en  in  1  read request.
- data_in  in  WIDTH  write data, sampled on an accepted write.
- data_out  out  WIDTH  read data (mode dependent, see Operation).
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  count ≥ AF_LEVEL.
- almost_empty  out  1  count ≤ AE_LEVEL.
- count  out  CW  current occupancy, 0..DEPTH.
- overflow  out  1  one-cycle pulse: a write was rejected.
- underflow  out  1  one-cycle pulse: a read was rejected.

## Operation
- Write accept: w_en && !full. The word is stored at wr_ptr, and wr_ptr advances.
- Read accept: r_en && !empty. rd_ptr advances.
- Pointer wrap: each pointer goes DEPTH-1 → 0. This must be an explicit compare, not a modulo-2^n wrap.
- Count update per edge: +1 on a write-only accept, −1 on a read-only accept, unchanged when both or neither are accepted.
- Flag derivation: full, empty, almost_full and almost_empty are decoded from the count register, so they change in the same cycle as count.
- Simultaneous w_en and r_en:
  - When full: the read is accepted and the write is rejected. overflow pulses; count goes to DEPTH-1.
  - When empty: the write is accepted and the read is rejected. underflow pulses; count goes to 1.
  - Otherwise: both are accepted and count is unchanged.
- overflow: registered and high for exactly one cycle after an edge where w_en && full. It is not sticky.
- underflow: registered and high for exactly one cycle after an edge where r_en && empty. It is not sticky.
- FWFT=0: data_out is a register loaded with mem[rd_ptr] on an accepted read. It holds its value otherwise, including on a rejected read.
- FWFT=1: data_out = mem[rd_ptr] continuously. The value is valid whenever empty == 0, and undefined-but-stable (last head value) while empty. An accepted read presents the next word in the following cycle.
- Storage is not cleared by reset; only pointers, count and output registers are.
- Reset values (asynchronous, effective immediately while rst = 1):
  - wr_ptr = 0, rd_ptr = 0, count = 0.
  - empty = 1, full = 0, almost_empty = 1, almost_full = 0.
  - overflow = 0, underflow = 0, data_out = 0.
- Reset asserted mid-operation discards all contents. The first accepted write after release becomes the head.

## Timing
- Write to visibility: an accepted write at edge N gives empty = 0 and count incremented after edge N.
  - FWFT=1: data_out is valid after edge N.
  - FWFT=0: the earliest read is accepted at edge N+1, and data_out is valid after edge N+1.
- Read latency: FWFT=0 has 1 cycle from the accepted r_en edge to data_out. FWFT=1 has 0 cycles, because the head is already present.
- Full to write: full deasserts after the edge of an accepted read-only cycle. A write is accepted at the next edge.
- Error pulses: visible in the cycle after the offending edge, and last one cycle.
- Reset release: the first accepted write is at the first rising edge with rst = 0.

## Test plan
All scenarios use DEPTH=16, WIDTH=8, AF_LEVEL=14, AE_LEVEL=2.
- Reset check: hold rst for 2 cycles mid-traffic (count=5) → all outputs at their reset values. Next write 8'hA5 → count=1, empty=0; FWFT=0 read returns 8'hA5.
- Fill and flags: write 0x00..0x0F (16 writes, no reads).
  - almost_empty drops when count goes from 2 to 3.
  - almost_full rises at count=14.
  - full is 1 at count=16.
  - A 17th write → overflow pulse for 1 cycle; count stays 16; contents unchanged.
- Drain, wrap and underflow: continue from the full state.
  - Read 16 words → data 0x00..0x0F in order; empty=1 at count 0.
  - An extra read → underflow pulse for 1 cycle; data_out holds 0x0F.
  - Write 20 and read 20 interleaved → order is preserved across the pointer wrap.
- Simultaneous R/W:
  - At count=5, w_en=r_en=1 for 10 cycles → count stays 5; data is FIFO-ordered.
  - When full with both requests → count=15 and overflow=1.
  - When empty with both requests → count=1 and underflow=1.
- FWFT mode (FWFT=1): write 8'h3C when empty → data_out=8'h3C the cycle after the write with no read. Read → the next word appears in the following cycle.
- Non-power-of-two DEPTH=5: 12 writes interleaved with 12 reads → correct order, count never exceeds 5, and full is asserted at 5.
